// File: rtl/stump_mem_bridge_pkg.sv
// Shared definitions for the Stump memory bridge: FSM state encodings,
// access-kind codes and the request decode helper.
package stump_mem_bridge_pkg;

  typedef enum logic [1:0] {
    MB_IDLE   = 2'd0,
    MB_ACCESS = 2'd1,
    MB_DONE   = 2'd2
  } mb_state_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } mb_kind_t;

  // Fetch beats memory; within memory, a write beats a read.
  function automatic mb_kind_t decode_kind(input logic fetch, input logic mem_wen);
    if (fetch)
      return KIND_FETCH;
    else if (mem_wen)
      return KIND_STORE;
    else
      return KIND_LOAD;
  endfunction

endpackage

// File: rtl/stump_mem_timeout.sv
// Clear/enable cycle counter with a terminal-count flag, used to bound how
// long the bridge waits for an external acknowledge.
module stump_mem_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // Count enabled cycles; clear wins over enable so every fresh access starts at zero.
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= 8'd0;
    else if (enable)
      count <= count + 8'd1;
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/stump_mem_bridge.sv
// Stump memory-access sequencer: turns fetch/load/store requests from the
// control block into a req/ack bus transaction, stalling control until done.
// Optional feature macro: STUMP_MEM_STATS_EN adds access/wait statistics counters.
module stump_mem_bridge
  import stump_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch,
  input  logic        memory,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] ir,
  output logic [15:0] rdata,
  output logic        bus_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_wdata,
  input  logic [15:0] ext_rdata,
  input  logic        ext_ack
`ifdef STUMP_MEM_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] load_cnt,
  output logic [15:0] store_cnt,
  output logic [15:0] wait_cnt
`endif
);

  mb_state_t state, next_state;
  mb_kind_t  kind;
  logic      start;
  logic      in_access;
  logic      tc;

  assign in_access = (state == MB_ACCESS);

  stump_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_access),
    .enable (in_access),
    .tc     (tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= MB_IDLE;
    else
      state <= next_state;
  end

  // Next-state and stall decode; DONE suppresses start because control has not moved on yet.
  always_comb begin
    next_state = state;
    start      = (state == MB_IDLE) && (fetch || (memory && (mem_ren || mem_wen)));
    stall      = start || in_access;
    case (state)
      MB_IDLE:   if (start) next_state = MB_ACCESS;
      MB_ACCESS: if (ext_ack || tc) next_state = MB_DONE;
      MB_DONE:   next_state = MB_IDLE;
      default:   next_state = MB_IDLE;
    endcase
  end

  // Bus outputs and result registers; an ack in the timeout cycle still counts as success.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 16'h0000;
      kind      <= KIND_FETCH;
      ir        <= 16'h0000;
      rdata     <= 16'h0000;
      bus_err   <= 1'b0;
    end else begin
      ext_req <= (next_state == MB_ACCESS);
      if (start) begin
        kind      <= decode_kind(fetch, mem_wen);
        ext_we    <= (decode_kind(fetch, mem_wen) == KIND_STORE);
        ext_addr  <= addr;
        ext_wdata <= wdata;
      end
      if (in_access) begin
        if (ext_ack) begin
          if (kind == KIND_FETCH)
            ir <= ext_rdata;
          else if (kind == KIND_LOAD)
            rdata <= ext_rdata;
        end else if (tc) begin
          bus_err <= 1'b1;
          if (kind == KIND_FETCH)
            ir <= 16'h0000;
        end
      end
    end
  end

`ifdef STUMP_MEM_STATS_EN
  // Statistics: completed accesses by kind (wrapping) and unacknowledged access cycles (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 16'h0000;
      load_cnt  <= 16'h0000;
      store_cnt <= 16'h0000;
      wait_cnt  <= 16'h0000;
    end else if (in_access) begin
      if (ext_ack) begin
        if (kind == KIND_FETCH)
          fetch_cnt <= fetch_cnt + 16'd1;
        else if (kind == KIND_LOAD)
          load_cnt <= load_cnt + 16'd1;
        else
          store_cnt <= store_cnt + 16'd1;
      end else if (wait_cnt != 16'hFFFF) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stump_mem_bridge.sv
// Directed self-checking bench for stump_mem_bridge (TIMEOUT = 15).
module tb_stump_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch, memory, mem_ren, mem_wen;
  logic [15:0] addr, wdata;
  logic        stall;
  logic [15:0] ir, rdata;
  logic        bus_err;
  logic        ext_req, ext_we;
  logic [15:0] ext_addr, ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_ack;
`ifdef STUMP_MEM_STATS_EN
  logic [15:0] fetch_cnt, load_cnt, store_cnt, wait_cnt;
`endif

  int tests = 0;
  int fails = 0;

  stump_mem_bridge #(.TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fetch),
    .memory    (memory),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .ir        (ir),
    .rdata     (rdata),
    .bus_err   (bus_err),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack)
`ifdef STUMP_MEM_STATS_EN
    ,
    .fetch_cnt (fetch_cnt),
    .load_cnt  (load_cnt),
    .store_cnt (store_cnt),
    .wait_cnt  (wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic f, input logic m, input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    fetch   = f;
    memory  = m;
    mem_ren = r;
    mem_wen = w;
    addr    = a;
    wdata   = d;
    #1;
  endtask

  // Full access: start cycle, 'waits' unacknowledged ACCESS cycles, ack cycle, DONE, back to IDLE.
  task automatic doAccess(input string tag, input logic f, input logic m, input logic r,
                          input logic w, input logic [15:0] a, input logic [15:0] d,
                          input int waits, input logic [15:0] ack_data, input logic exp_we);
    applyStimulus(f, m, r, w, a, d);
    checkOutput({tag, "_start_stall"}, 16'(stall), 16'd1);
    tick;
    checkOutput({tag, "_req"}, 16'(ext_req), 16'd1);
    checkOutput({tag, "_addr"}, ext_addr, a);
    checkOutput({tag, "_we"}, 16'(ext_we), 16'(exp_we));
    if (exp_we)
      checkOutput({tag, "_wdata"}, ext_wdata, d);
    for (int i = 0; i < waits; i++) begin
      checkOutput({tag, "_wait_stall"}, 16'(stall), 16'd1);
      checkOutput({tag, "_wait_req"}, 16'(ext_req), 16'd1);
      tick;
    end
    ext_ack   = 1'b1;
    ext_rdata = ack_data;
    #1;
    checkOutput({tag, "_ack_stall"}, 16'(stall), 16'd1);
    tick;
    ext_ack = 1'b0;
    #1;
    checkOutput({tag, "_done_req"}, 16'(ext_req), 16'd0);
    checkOutput({tag, "_done_stall"}, 16'(stall), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
  endtask

  initial begin
    rst       = 1'b1;
    ext_ack   = 1'b0;
    ext_rdata = 16'h0000;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
    tick;

    // Reset state
    checkOutput("rst_ir", ir, 16'h0000);
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_bus_err", 16'(bus_err), 16'd0);
    checkOutput("rst_req", 16'(ext_req), 16'd0);
    checkOutput("rst_we", 16'(ext_we), 16'd0);
    checkOutput("rst_addr", ext_addr, 16'h0000);
    checkOutput("rst_wdata", ext_wdata, 16'h0000);
    rst = 1'b0;
    tick;

    // Execute-only cycle: memory state without ren/wen passes through
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000);
    checkOutput("exec_stall", 16'(stall), 16'd0);
    tick;
    checkOutput("exec_req", 16'(ext_req), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // 1. Fetch with minimum latency
    doAccess("t1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hA5C3, 1'b0);
    checkOutput("t1_ir", ir, 16'hA5C3);
    checkOutput("t1_rdata", rdata, 16'h0000);

    // 2. Load with 3 wait cycles
    doAccess("t2", 1'b0, 1'b1, 1'b1, 1'b0, 16'h2000, 16'h0000, 3, 16'h1234, 1'b0);
    checkOutput("t2_rdata", rdata, 16'h1234);
    checkOutput("t2_ir", ir, 16'hA5C3);

    // 3. Store
    doAccess("t3", 1'b0, 1'b1, 1'b0, 1'b1, 16'h3000, 16'hBEEF, 0, 16'h5555, 1'b1);
    checkOutput("t3_rdata", rdata, 16'h1234);
    checkOutput("t3_ir", ir, 16'hA5C3);
    checkOutput("t3_bus_err", 16'(bus_err), 16'd0);

    // 4. Fetch with no ack: abort after 15 ACCESS cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
    tick;
    for (int i = 0; i < 14; i++)
      tick;
    checkOutput("t4_req_last", 16'(ext_req), 16'd1);
    checkOutput("t4_stall_last", 16'(stall), 16'd1);
    tick;
    checkOutput("t4_req_drop", 16'(ext_req), 16'd0);
    checkOutput("t4_bus_err", 16'(bus_err), 16'd1);
    checkOutput("t4_ir", ir, 16'h0000);
    checkOutput("t4_done_stall", 16'(stall), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
    checkOutput("t4_err_sticky", 16'(bus_err), 16'd1);
    doAccess("t4b", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0000, 0, 16'h1111, 1'b0);
    checkOutput("t4b_ir", ir, 16'h1111);
    checkOutput("t4b_bus_err", 16'(bus_err), 16'd1);

    // 5. Reset in the 2nd ACCESS cycle, late ack ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000);
    tick;
    tick;
    rst = 1'b1;
    tick;
    checkOutput("t5_req", 16'(ext_req), 16'd0);
    checkOutput("t5_ir", ir, 16'h0000);
    checkOutput("t5_bus_err", 16'(bus_err), 16'd0);
    rst       = 1'b0;
    ext_ack   = 1'b1;
    ext_rdata = 16'h7777;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    tick;
    ext_ack = 1'b0;
    #1;
    checkOutput("t5_late_ir", ir, 16'h0000);
    checkOutput("t5_late_rdata", rdata, 16'h0000);
    checkOutput("t5_late_req", 16'(ext_req), 16'd0);
    checkOutput("t5_late_stall", 16'(stall), 16'd0);

    // 6a. Load acked in the timeout cycle: ack wins
    doAccess("t6a", 1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h0000, 14, 16'h9ABC, 1'b0);
    checkOutput("t6a_rdata", rdata, 16'h9ABC);
    checkOutput("t6a_bus_err", 16'(bus_err), 16'd0);

    // 6b. Both mem_ren and mem_wen: write issued
    doAccess("t6b", 1'b0, 1'b1, 1'b1, 1'b1, 16'h5000, 16'hCAFE, 0, 16'h0BAD, 1'b1);
    checkOutput("t6b_rdata", rdata, 16'h9ABC);
    checkOutput("t6b_ir", ir, 16'h0000);
    checkOutput("t6b_bus_err", 16'(bus_err), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
